// File: rtl/ad_scan_ctrl.sv
// Multi-channel AD scan controller: sweeps the analog mux, waits a settle time per
// channel, captures each sample into an on-chip FIFO and optionally appends CR/LF.
module ad_scan_ctrl #(
  parameter int DW      = 8,
  parameter int CH_N    = 32,
  parameter int AW      = 5,
  parameter int SETTLE  = 1000000,
  parameter int CYCLES  = 3,
  parameter int FIFO_AW = 12,
  parameter int TERM_EN = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DW-1:0]      ad_data,
  output logic [AW-1:0]      addr,
  output logic               sample,
  output logic               busy,
  output logic               done,
  input  logic               rdreq,
  output logic [DW-1:0]      q,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   usedw,
  output logic [3:0]         state_dbg
);

  localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SW    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [SW-1:0]    SWEEP_LAST  = SW'(CYCLES - 1);
  localparam logic [AW-1:0]    ADDR_LAST   = AW'(CH_N - 1);
  localparam logic [FIFO_AW:0] FULL_LEVEL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [DW-1:0]    CR_WORD     = DW'(8'h0D);
  localparam logic [DW-1:0]    LF_WORD     = DW'(8'h0A);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SETTLE  = 4'd1,
    S_SAMPLE  = 4'd2,
    S_NEXT    = 4'd3,
    S_TERM_CR = 4'd4,
    S_TERM_LF = 4'd5,
    S_DONE    = 4'd6
  } state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     addr_reg, addr_next;
  logic [SW-1:0]     sweep_reg, sweep_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              start_d_reg;
  logic              start_edge;

  logic              wr_int;
  logic [DW-1:0]     wr_data;

  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]   usedw_reg, usedw_next;
  logic [DW-1:0]      q_reg;
  logic [DW-1:0]      mem [DEPTH];
  logic               do_wr, do_rd;

  assign start_edge = start & ~start_d_reg;

  // ---------------------------------------------------------------------------
  // Scan sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      addr_reg    <= '0;
      sweep_reg   <= '0;
      cnt_reg     <= '0;
      start_d_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      sweep_reg   <= sweep_next;
      cnt_reg     <= cnt_next;
      start_d_reg <= start;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    sweep_next = sweep_reg;
    cnt_next   = cnt_reg;
    wr_int     = 1'b0;
    wr_data    = ad_data;
    sample     = 1'b0;
    done       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        addr_next  = '0;
        sweep_next = '0;
        cnt_next   = '0;
        if (start_edge) begin
          state_next = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_reg == SETTLE_LAST) begin
          cnt_next   = '0;
          state_next = S_SAMPLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      // A full FIFO holds the sequencer here so no sample is ever lost.
      S_SAMPLE: begin
        wr_int = 1'b1;
        if (!full) begin
          sample     = 1'b1;
          state_next = S_NEXT;
        end
      end

      S_NEXT: begin
        if (addr_reg == ADDR_LAST && sweep_reg == SWEEP_LAST) begin
          state_next = (TERM_EN != 0) ? S_TERM_CR : S_DONE;
        end else if (addr_reg == ADDR_LAST) begin
          addr_next  = '0;
          sweep_next = sweep_reg + SW'(1);
          state_next = S_SETTLE;
        end else begin
          addr_next  = addr_reg + AW'(1);
          state_next = S_SETTLE;
        end
      end

      // Terminator words are dropped entirely if the scan is being aborted.
      S_TERM_CR: begin
        wr_int  = ~abort;
        wr_data = CR_WORD;
        if (!full) begin
          state_next = S_TERM_LF;
        end
      end

      S_TERM_LF: begin
        wr_int  = ~abort;
        wr_data = LF_WORD;
        if (!full) begin
          state_next = S_DONE;
        end
      end

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (abort && state_reg != S_IDLE) begin
      state_next = S_IDLE;
      addr_next  = '0;
      sweep_next = '0;
      cnt_next   = '0;
    end
  end

  assign addr      = addr_reg;
  assign busy      = (state_reg != S_IDLE);
  assign state_dbg = state_reg;

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  assign full  = (usedw_reg == FULL_LEVEL);
  assign empty = (usedw_reg == '0);
  assign do_wr = wr_int & ~full;
  assign do_rd = rdreq & ~empty;

  always_comb begin
    usedw_next = usedw_reg;
    case ({do_wr, do_rd})
      2'b10:   usedw_next = usedw_reg + (FIFO_AW + 1)'(1);
      2'b01:   usedw_next = usedw_reg - (FIFO_AW + 1)'(1);
      default: usedw_next = usedw_reg;
    endcase
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      usedw_reg  <= '0;
      q_reg      <= '0;
    end else begin
      usedw_reg <= usedw_next;
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
      end
      if (do_rd) begin
        q_reg      <= mem[rd_ptr_reg];
        rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
      end
    end
  end

  assign q     = q_reg;
  assign usedw = usedw_reg;

endmodule

// File: tb/tb_ad_scan_ctrl.sv
// Scoreboard bench for ad_scan_ctrl: expected samples and FIFO words are queued when a
// scan is launched; negedge monitors pop and compare as the DUT produces them.
module tb_ad_scan_ctrl;

  localparam int SETTLE = 3;
  localparam int PER    = SETTLE + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start, abort, rdreq;
  logic [7:0] ad_data;
  logic [1:0] addr;
  logic       sample, busy, done, empty, full;
  logic [7:0] q;
  logic [3:0] usedw;
  logic [3:0] state_dbg;

  logic       start1, abort1, rdreq1;
  logic [7:0] ad_data1;
  logic [1:0] addr1;
  logic       sample1, busy1, done1, empty1, full1;
  logic [7:0] q1;
  logic [3:0] usedw1;
  logic [3:0] state_dbg1;

  logic [7:0] tbl  [4];
  logic [7:0] tbl1 [4];
  assign ad_data  = tbl[addr];
  assign ad_data1 = tbl1[addr1];

  ad_scan_ctrl #(.DW(8), .CH_N(4), .AW(2), .SETTLE(SETTLE), .CYCLES(2), .FIFO_AW(3), .TERM_EN(1)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .ad_data(ad_data),
    .addr(addr), .sample(sample), .busy(busy), .done(done), .rdreq(rdreq), .q(q),
    .empty(empty), .full(full), .usedw(usedw), .state_dbg(state_dbg)
  );

  ad_scan_ctrl #(.DW(8), .CH_N(4), .AW(2), .SETTLE(SETTLE), .CYCLES(2), .FIFO_AW(3), .TERM_EN(0)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort1), .ad_data(ad_data1),
    .addr(addr1), .sample(sample1), .busy(busy1), .done(done1), .rdreq(rdreq1), .q(q1),
    .empty(empty1), .full(full1), .usedw(usedw1), .state_dbg(state_dbg1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int a;
    int c;
  } samp_t;

  samp_t      exp_samp[$];
  logic [7:0] exp_rd[$];
  logic [7:0] got1[$];
  int         done_cnt = 0;
  int         done1_cyc = -1;
  int         samp1_cnt = 0;
  bit         full1_seen = 1'b0;
  bit         pend_rd = 1'b0;
  bit         pend1 = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference scan: sweep-major channel order, one sample every SETTLE+2 cycles.
  task automatic push_scan(input int s, input int nsamp, input bit term);
    samp_t e;
    for (int k = 0; k < nsamp; k++) begin
      e.a = k % 4;
      e.c = s + SETTLE + 1 + PER * k;
      exp_samp.push_back(e);
      exp_rd.push_back(tbl[k % 4]);
    end
    if (term) begin
      exp_rd.push_back(8'h0D);
      exp_rd.push_back(8'h0A);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    rdreq = 1'b1;
    while (!empty && n < 20) begin
      tick(1);
      n++;
    end
    rdreq = 1'b0;
    tick(2);
    chk("drain_empty", empty, 1);
    chk("drain_all_read", exp_rd.size(), 0);
  endtask

  always @(negedge clk) begin
    samp_t s;
    if (!reset_n) begin
      pend_rd = 1'b0;
      pend1   = 1'b0;
    end else begin
      if (pend_rd) begin
        if (exp_rd.size() == 0) chk("unexpected_read", 1, 0);
        else chk("q_word", q, exp_rd.pop_front());
      end
      pend_rd = rdreq && !empty;
      if (sample) begin
        if (exp_samp.size() == 0) chk("unexpected_sample", 1, 0);
        else begin
          s = exp_samp.pop_front();
          chk("sample_addr", addr, s.a);
          chk("sample_cycle", cyc, s.c);
        end
      end
      if (done) done_cnt++;
      if (pend1) got1.push_back(q1);
      pend1 = rdreq1 && !empty1;
      if (full1) full1_seen = 1'b1;
      if (done1) done1_cyc = cyc;
      if (sample1) samp1_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int s, n, busy_cnt;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; rdreq = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; rdreq1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tbl[i]  = 8'h10 + 8'(i);
      tbl1[i] = 8'($urandom);
    end
    tick(3);
    chk("rst_state", state_dbg, 0);
    chk("rst_addr", addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sample", sample, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_usedw", usedw, 0);
    chk("rst_q", q, 0);
    reset_n = 1'b1;
    tick(2);

    // Basic scan, start kept high the whole time; FIFO fills and stalls in TERM_CR.
    start = 1'b1;
    s = cyc;
    push_scan(s, 8, 1'b1);
    n = 0;
    while (state_dbg != 4'd4 && n < 100) begin tick(1); n++; end
    chk("reach_term_cr", state_dbg, 4);
    tick(5);
    chk("stall_state", state_dbg, 4);
    chk("stall_busy", busy, 1);
    chk("stall_full", full, 1);
    chk("stall_usedw", usedw, 8);
    chk("stall_no_done", done_cnt, 0);
    chk("all_samples_seen", exp_samp.size(), 0);

    rdreq = 1'b1; tick(1); rdreq = 1'b0;
    tick(1);
    chk("cr_written_state", state_dbg, 5);
    chk("cr_written_usedw", usedw, 8);
    tick(3);
    chk("lf_stall_state", state_dbg, 5);
    chk("lf_stall_no_done", done_cnt, 0);
    rdreq = 1'b1; tick(1); rdreq = 1'b0;
    tick(2);
    chk("done_once", done_cnt, 1);
    chk("after_done_busy", busy, 0);
    chk("after_done_usedw", usedw, 8);

    busy_cnt = 0;
    repeat (100) begin
      tick(1);
      if (busy) busy_cnt++;
    end
    chk("start_held_no_retrigger", busy_cnt, 0);
    start = 1'b0;
    drain();

    // Abort in sweep 1 at addr 2, with a start re-pulse while busy.
    for (int i = 0; i < 4; i++) tbl[i] = 8'($urandom);
    start = 1'b1;
    s = cyc;
    push_scan(s, 6, 1'b0);
    tick(1); start = 1'b0;
    tick(1); start = 1'b1;
    tick(1); start = 1'b0;
    while (cyc < s + 32) tick(1);
    chk("pre_abort_addr", addr, 2);
    chk("pre_abort_state", state_dbg, 1);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("abort_state", state_dbg, 0);
    chk("abort_addr", addr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_usedw", usedw, 6);
    tick(20);
    chk("abort_no_done", done_cnt, 1);
    chk("abort_usedw_hold", usedw, 6);
    chk("abort_samples_seen", exp_samp.size(), 0);
    drain();

    // Asynchronous reset mid-SETTLE with 5 words stored.
    for (int i = 0; i < 4; i++) tbl[i] = 8'($urandom);
    start = 1'b1;
    s = cyc;
    push_scan(s, 8, 1'b1);
    tick(1); start = 1'b0;
    while (cyc < s + 27) tick(1);
    chk("pre_rst_usedw", usedw, 5);
    chk("pre_rst_state", state_dbg, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_usedw", usedw, 0);
    chk("arst_addr", addr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_q", q, 0);
    exp_samp.delete();
    exp_rd.delete();
    tick(2);
    reset_n = 1'b1;
    rdreq = 1'b1; tick(1); rdreq = 1'b0;
    tick(1);
    chk("rd_empty_q", q, 0);
    chk("rd_empty_usedw", usedw, 0);

    // No-terminator instance, reader always requesting: no stall, fixed duration.
    start1 = 1'b1;
    s = cyc;
    tick(1); start1 = 1'b0;
    n = 0;
    while (done1_cyc < 0 && n < 200) begin tick(1); n++; end
    chk("u1_done_seen", (done1_cyc >= 0) ? 1 : 0, 1);
    chk("u1_duration", done1_cyc - s + 1, 8 * PER + 2);
    tick(3);
    chk("u1_never_full", full1_seen, 0);
    chk("u1_samples", samp1_cnt, 8);
    chk("u1_empty", empty1, 1);
    chk("u1_usedw", usedw1, 0);
    chk("u1_idle", state_dbg1, 0);
    chk("u1_busy", busy1, 0);
    chk("u1_addr", addr1, 0);
    chk("u1_words", got1.size(), 8);
    for (int i = 0; i < got1.size(); i++) chk("u1_word", got1[i], tbl1[i % 4]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad_scan_ctrl.md
Name: ad_scan_ctrl

Overview:
- Parametrised multi-channel AD scan controller with an integrated FIFO.
- Steps a channel address through CH_N channels and waits a programmable settle time per channel.
- Captures each AD sample into an internal synchronous FIFO and repeats for CYCLES sweeps.
- Optionally appends a CR/LF terminator. The UART/host side drains the FIFO via rdreq.
- Successor to the fixed 32-channel, 8-bit poller. Adds start-edge detection, abort, back-pressure stall on FIFO full, and status outputs.

Parameters:
- DW, 8, AD sample / FIFO word width.
- CH_N, 32, number of channels per sweep (2..2^AW).
- AW, 5, address width.
- SETTLE, 1000000, settle cycles per channel (>=1).
- CYCLES, 3, sweeps per scan (>=1).
- FIFO_AW, 12, FIFO depth = 2^FIFO_AW words.
- TERM_EN, 1, 1 = append 8'h0D then 8'h0A after the last sample (upper bits zero if DW>8).

Ports:
- clk, input, 1, system clock (50 MHz).
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, scan request; the rising edge is detected internally.
- abort, input, 1, synchronous abort, level high.
- ad_data, input, DW, AD sample for the currently addressed channel.
- addr, output, AW, channel address driven to the analog mux.
- sample, output, 1, one-cycle pulse on the cycle ad_data is captured.
- busy, output, 1, high while a scan is in progress (state != IDLE).
- done, output, 1, one-cycle pulse when a scan completes normally.
- rdreq, input, 1, FIFO read request.
- q, output, DW, FIFO read data.
- empty, output, 1, FIFO empty.
- full, output, 1, FIFO full.
- usedw, output, FIFO_AW+1, FIFO occupancy (0..2^FIFO_AW).
- state_dbg, output, 4, current FSM state encoding (debug).

Behaviour:
- Reset (async, reset_n=0) values:
  - state IDLE, addr=0, sample=0, busy=0, done=0.
  - FIFO cleared: empty=1, full=0, usedw=0, q=0.
  - Settle counter, sweep counter and start-edge register all 0.
- State encodings: IDLE=0, SETTLE=1, SAMPLE=2, NEXT=3, TERM_CR=4, TERM_LF=5, DONE=6.
- IDLE:
  - A start rising edge (start=1 this cycle, 0 the previous cycle) moves to SETTLE with addr=0 and sweep=0.
  - A start held high does not retrigger.
  - start is ignored outside IDLE.
- SETTLE:
  - The counter runs 0..SETTLE-1, so the state lasts exactly SETTLE cycles.
  - Then go to SAMPLE.
  - addr is stable throughout.
- SAMPLE:
  - If full=0: write ad_data to the FIFO, pulse sample, go to NEXT.
  - If full=1: remain in SAMPLE with no write and no sample pulse (stall). Write on the first cycle full=0.
  - No data is ever dropped.
- NEXT:
  - If addr==CH_N-1 and sweep==CYCLES-1: go to TERM_CR if TERM_EN, else DONE.
  - Else if addr==CH_N-1: addr<=0, sweep<=sweep+1, go to SETTLE.
  - Else: addr<=addr+1, go to SETTLE.
- TERM_CR / TERM_LF:
  - Write 8'h0D then 8'h0A, one cycle each.
  - Each stalls while full=1, same rule as SAMPLE.
- DONE: done=1 for one cycle, then IDLE. addr returns to 0 in IDLE.
- Per-sample latency, unstalled: SETTLE+2 cycles. Total FIFO words per scan: CH_N*CYCLES (+2 if TERM_EN).
- abort=1 in any non-IDLE state:
  - Go to IDLE next cycle and clear addr/sweep/counter.
  - No terminator, no done pulse.
  - FIFO contents retained.
  - If abort coincides with a SAMPLE write, that write still completes.
- FIFO (synchronous, single clock, normal mode):
  - A write occurs when wr_int=1 and full=0.
  - A read occurs when rdreq=1 and empty=0. q updates on the clock edge of the read and holds otherwise.
  - rdreq when empty: ignored, q unchanged.
  - Simultaneous read and write with 0<usedw<depth: usedw unchanged.
  - Read and write on an empty FIFO: only the write takes effect.
  - When full, the controller stalls even if rdreq is asserted on the same cycle; the write proceeds next cycle.
  - Pointers wrap modulo 2^FIFO_AW. full = (usedw==2^FIFO_AW); empty = (usedw==0).
- Counters are sized to hold SETTLE-1 and CYCLES-1 without overflow.

Test Plan (CH_N=4, SETTLE=3, CYCLES=2, FIFO_AW=3, TERM_EN=1, AW=2, DW=8):
- Basic scan, rdreq=0, ad_data=8'h10+addr, start edge:
  - addr sequence 0,1,2,3,0,1,2,3.
  - sample pulses 5 cycles apart.
  - FIFO receives 10,11,12,13,10,11,12,13 and then becomes full (usedw=8).
  - FSM stalls in TERM_CR, busy stays 1, no done.
- Drain from the stalled state, asserting rdreq for 1 cycle:
  - 0D is written the next cycle, then the FSM stalls in TERM_LF.
  - A second read lets 0A be written, then done pulses once and busy drops.
  - Reading all words returns 12,13,10,11,12,13,0D,0A in order.
- Start held high for 100 cycles after a scan completes -> no second scan (edge only). A start re-pulse while busy is ignored.
- Abort during the second sweep at addr=2, FIFO not full:
  - Next cycle state=IDLE, addr=0.
  - usedw equals the samples already written; no 0D/0A; done stays 0.
- reset_n asserted mid-SETTLE with usedw=5 -> immediately empty=1, usedw=0, addr=0, busy=0. rdreq after reset: q stays 0.
- Continuous rdreq during a scan with TERM_EN=0 -> the FIFO never fills, there is no stall, and the scan takes exactly 8*(SETTLE+2)+2 cycles from the start edge to done.
